// File: rtl/pkt_cell_writer.sv
// Ingress segmentation stage: one free-list cell per beat, one buffer write and link write
// per beat, one descriptor per packet to the traffic manager.
module pkt_cell_writer #(
    parameter int  CELL_ID_W = 12,
    parameter int  MAX_CELLS = 32,
    parameter int  LEN_W     = 14,
    localparam int CNT_W     = $clog2(MAX_CELLS) + 1
) (
    input  logic                 clk_dp,
    input  logic                 rst_dp,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [511:0]         in_data,
    input  logic                 in_sof,
    input  logic                 in_eof,
    input  logic [6:0]           in_len,
    output logic                 alloc_req,
    input  logic                 alloc_valid,
    input  logic [CELL_ID_W-1:0] alloc_id,
    output logic                 wr_valid,
    output logic [CELL_ID_W-1:0] wr_cell_id,
    output logic [511:0]         wr_data,
    output logic                 wr_sof,
    output logic                 wr_eof,
    output logic [6:0]           wr_data_len,
    output logic                 link_we,
    output logic [CELL_ID_W-1:0] link_cell,
    output logic [CELL_ID_W-1:0] link_next,
    output logic                 desc_valid,
    input  logic                 desc_ready,
    output logic [CELL_ID_W-1:0] desc_head,
    output logic [CELL_ID_W-1:0] desc_tail,
    output logic [LEN_W-1:0]     desc_len,
    output logic [CNT_W-1:0]     desc_cells,
    output logic                 desc_err,
    output logic [15:0]          drop_cnt,
    output logic [15:0]          err_cnt
);

    typedef enum logic [1:0] {IDLE, BODY, DISCARD} state_t;

    state_t                 state;
    logic [CELL_ID_W-1:0]   head;
    logic [CELL_ID_W-1:0]   tail;
    logic [LEN_W-1:0]       len_acc;
    logic [CNT_W-1:0]       cells_acc;

    logic                   accept;
    logic                   start;
    logic                   take_cell;
    logic                   trunc;
    logic                   close;
    logic                   drop_inc;
    logic [1:0]             err_inc;
    logic [16:0]            err_sum;
    logic [CNT_W-1:0]       new_cells;
    logic [LEN_W-1:0]       new_len;
    logic [CELL_ID_W-1:0]   new_head;

    // An undrained descriptor only blocks beats that would need a cell; DISCARD always drains.
    always_comb begin
        // NOTE: default assignment first so no path through the block can infer a latch.
        in_ready = 1'b1;
        if (state != DISCARD)
            in_ready = alloc_valid & ~(desc_valid & ~desc_ready);
    end

    assign accept    = in_valid & in_ready;
    assign start     = (state == IDLE);
    assign take_cell = accept & ((state == BODY) | (start & in_sof));
    assign alloc_req = take_cell;

    assign new_cells = start ? CNT_W'(1) : cells_acc + CNT_W'(1);
    assign new_len   = (start ? '0 : len_acc) + LEN_W'(in_len);
    assign new_head  = start ? alloc_id : head;
    assign trunc     = take_cell & ~in_eof & (new_cells == CNT_W'(MAX_CELLS));
    assign close     = take_cell & (in_eof | trunc);

    assign drop_inc  = accept & start & ~in_sof;
    assign err_inc   = {1'b0, accept & (state == BODY) & in_sof} + {1'b0, trunc};
    assign err_sum   = {1'b0, err_cnt} + {15'b0, err_inc};

    always_ff @(posedge clk_dp or posedge rst_dp) begin
        if (rst_dp) begin
            state       <= IDLE;
            head        <= '0;
            tail        <= '0;
            len_acc     <= '0;
            cells_acc   <= '0;
            wr_valid    <= 1'b0;
            wr_cell_id  <= '0;
            wr_data     <= '0;
            wr_sof      <= 1'b0;
            wr_eof      <= 1'b0;
            wr_data_len <= '0;
            link_we     <= 1'b0;
            link_cell   <= '0;
            link_next   <= '0;
            desc_valid  <= 1'b0;
            desc_head   <= '0;
            desc_tail   <= '0;
            desc_len    <= '0;
            desc_cells  <= '0;
            desc_err    <= 1'b0;
            drop_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            // NOTE: non-blocking everywhere here so every register samples pre-edge values.
            wr_valid <= take_cell;
            link_we  <= take_cell & (state == BODY);

            if (take_cell) begin
                wr_cell_id  <= alloc_id;
                wr_data     <= in_data;
                wr_sof      <= start;
                wr_eof      <= in_eof | trunc;
                wr_data_len <= in_len;
                head        <= new_head;
                tail        <= alloc_id;
                len_acc     <= new_len;
                cells_acc   <= new_cells;
            end

            if (take_cell && state == BODY) begin
                link_cell <= tail;
                link_next <= alloc_id;
            end

            // A drain and a new close in the same cycle: the new descriptor wins.
            if (desc_ready)
                desc_valid <= 1'b0;
            if (close) begin
                desc_valid <= 1'b1;
                desc_head  <= new_head;
                desc_tail  <= alloc_id;
                desc_len   <= new_len;
                desc_cells <= new_cells;
                desc_err   <= trunc;
            end

            if (accept) begin
                case (state)
                    IDLE:    if (in_sof && !in_eof) state <= trunc ? DISCARD : BODY;
                    BODY:    if (in_eof)            state <= IDLE;
                             else if (trunc)        state <= DISCARD;
                    DISCARD: if (in_eof)            state <= IDLE;
                    default:                        state <= IDLE;
                endcase
            end

            if (drop_inc && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

endmodule

// File: tb/tb_pkt_cell_writer.sv
// Directed bench for pkt_cell_writer: inputs driven on the falling edge, outputs sampled
// on the falling edge or 1 time unit after the rising edge.
module tb_pkt_cell_writer;

    localparam int CELL_ID_W = 12;
    localparam int MAX_CELLS = 32;
    localparam int LEN_W     = 14;
    localparam int CNT_W     = $clog2(MAX_CELLS) + 1;

    logic                 clk_dp = 1'b0;
    logic                 rst_dp;
    logic                 in_valid, in_ready, in_sof, in_eof;
    logic [511:0]         in_data;
    logic [6:0]           in_len;
    logic                 alloc_req, alloc_valid;
    logic [CELL_ID_W-1:0] alloc_id;
    logic                 wr_valid, wr_sof, wr_eof;
    logic [CELL_ID_W-1:0] wr_cell_id;
    logic [511:0]         wr_data;
    logic [6:0]           wr_data_len;
    logic                 link_we;
    logic [CELL_ID_W-1:0] link_cell, link_next;
    logic                 desc_valid, desc_ready, desc_err;
    logic [CELL_ID_W-1:0] desc_head, desc_tail;
    logic [LEN_W-1:0]     desc_len;
    logic [CNT_W-1:0]     desc_cells;
    logic [15:0]          drop_cnt, err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CELL_ID_W-1:0] id;
        logic                 sof;
        logic                 eof;
        logic [6:0]           len;
    } wr_rec_t;

    wr_rec_t                  wr_q[$];
    logic [2*CELL_ID_W-1:0]   link_q[$];

    pkt_cell_writer #(.CELL_ID_W(CELL_ID_W), .MAX_CELLS(MAX_CELLS), .LEN_W(LEN_W)) dut (
        .clk_dp(clk_dp), .rst_dp(rst_dp),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof), .in_len(in_len),
        .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_id(alloc_id),
        .wr_valid(wr_valid), .wr_cell_id(wr_cell_id), .wr_data(wr_data),
        .wr_sof(wr_sof), .wr_eof(wr_eof), .wr_data_len(wr_data_len),
        .link_we(link_we), .link_cell(link_cell), .link_next(link_next),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_head(desc_head), .desc_tail(desc_tail), .desc_len(desc_len),
        .desc_cells(desc_cells), .desc_err(desc_err),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    always #5 clk_dp = ~clk_dp;

    always @(posedge clk_dp) begin
        #1;
        if (wr_valid) wr_q.push_back('{wr_cell_id, wr_sof, wr_eof, wr_data_len});
        if (link_we)  link_q.push_back({link_cell, link_next});
    end

    function automatic logic [511:0] pattern(input logic [CELL_ID_W-1:0] id);
        return {16{id, 20'h5A5A5}};
    endfunction

    // Called at a falling edge; returns at the falling edge right after the accepting edge.
    task automatic drive_beat(input logic sof, input logic eof, input logic [6:0] len,
                              input logic [CELL_ID_W-1:0] id, input logic exp_alloc);
        int n = 0;
        in_valid = 1'b1; in_sof = sof; in_eof = eof; in_len = len;
        alloc_id = id;   in_data = pattern(id);
        #1;
        while (!in_ready && n < 100) begin @(negedge clk_dp); #1; n++; end
        checks++;
        if (!in_ready) begin
            errors++; $display("FAIL beat_timeout id=%0d: in_ready=0, want 1", id);
        end
        checks++;
        if (alloc_req !== exp_alloc) begin
            errors++; $display("FAIL alloc_req id=%0d: got %b want %b", id, alloc_req, exp_alloc);
        end
        @(negedge clk_dp);
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    endtask

    task automatic consume_desc();
        desc_ready = 1'b1;
        @(negedge clk_dp);
        desc_ready = 1'b0;
        #1;
        checks++;
        if (desc_valid !== 1'b0) begin
            errors++; $display("FAIL desc_drain: desc_valid=%b want 0", desc_valid);
        end
        @(negedge clk_dp);
    endtask

    task automatic test_reset();
        rst_dp = 1'b1;
        repeat (2) @(negedge clk_dp);
        rst_dp = 1'b0;
        @(negedge clk_dp);
        checks++;
        if ({wr_valid, link_we, desc_valid, alloc_req} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b want 0000", {wr_valid, link_we, desc_valid, alloc_req});
        end
        checks++;
        if ({drop_cnt, err_cnt} !== 32'h0) begin
            errors++; $display("FAIL reset_counters: got drop=%0d err=%0d want 0/0", drop_cnt, err_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single_beat();
        drive_beat(1'b1, 1'b1, 7'd40, 12'd5, 1'b1);
        checks++;
        if ({wr_valid, wr_cell_id, wr_sof, wr_eof, wr_data_len} !== {1'b1, 12'd5, 1'b1, 1'b1, 7'd40}) begin
            errors++; $display("FAIL single_wr: got v=%b id=%0d sof=%b eof=%b len=%0d want 1/5/1/1/40",
                               wr_valid, wr_cell_id, wr_sof, wr_eof, wr_data_len);
        end
        checks++;
        if (wr_data !== pattern(12'd5)) begin
            errors++; $display("FAIL single_data: got %h want %h", wr_data[63:0], pattern(12'd5) >> 448);
        end
        checks++;
        if (link_we !== 1'b0) begin
            errors++; $display("FAIL single_link: link_we=%b want 0", link_we);
        end
        checks++;
        if ({desc_valid, desc_head, desc_tail, desc_len, desc_cells, desc_err} !==
            {1'b1, 12'd5, 12'd5, 14'd40, 6'd1, 1'b0}) begin
            errors++; $display("FAIL single_desc: got v=%b h=%0d t=%0d len=%0d cells=%0d err=%b want 1/5/5/40/1/0",
                               desc_valid, desc_head, desc_tail, desc_len, desc_cells, desc_err);
        end
        @(negedge clk_dp);
        checks++;
        if (wr_valid !== 1'b0) begin
            errors++; $display("FAIL single_pulse: wr_valid=%b want 0", wr_valid);
        end
        consume_desc();
    endtask

    task automatic test_multi_beat();
        wr_q.delete(); link_q.delete();
        drive_beat(1'b1, 1'b0, 7'd64, 12'd7, 1'b1);
        drive_beat(1'b0, 1'b0, 7'd64, 12'd8, 1'b1);
        drive_beat(1'b0, 1'b1, 7'd10, 12'd9, 1'b1);
        checks++;
        if ({desc_valid, desc_head, desc_tail, desc_len, desc_cells, desc_err} !==
            {1'b1, 12'd7, 12'd9, 14'd138, 6'd3, 1'b0}) begin
            errors++; $display("FAIL multi_desc: got v=%b h=%0d t=%0d len=%0d cells=%0d err=%b want 1/7/9/138/3/0",
                               desc_valid, desc_head, desc_tail, desc_len, desc_cells, desc_err);
        end
        checks++;
        if (wr_q.size() != 3 || wr_q[0] !== '{12'd7, 1'b1, 1'b0, 7'd64} ||
            wr_q[1] !== '{12'd8, 1'b0, 1'b0, 7'd64} || wr_q[2] !== '{12'd9, 1'b0, 1'b1, 7'd10}) begin
            errors++; $display("FAIL multi_writes: got %0d writes, want 3 as 7(sof)/8/9(eof)", wr_q.size());
        end
        checks++;
        if (link_q.size() != 2 || link_q[0] !== {12'd7, 12'd8} || link_q[1] !== {12'd8, 12'd9}) begin
            errors++; $display("FAIL multi_links: got %0d links, want (7->8),(8->9)", link_q.size());
        end
        consume_desc();
    endtask

    task automatic test_alloc_stall();
        wr_q.delete(); link_q.delete();
        drive_beat(1'b1, 1'b0, 7'd64, 12'd20, 1'b1);
        alloc_valid = 1'b0;
        in_valid = 1'b1; in_len = 7'd64; alloc_id = 12'd21; in_data = pattern(12'd21);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || alloc_req !== 1'b0) begin
                errors++; $display("FAIL stall_ready cyc%0d: in_ready=%b alloc_req=%b want 0/0", i, in_ready, alloc_req);
            end
            @(negedge clk_dp);
        end
        alloc_valid = 1'b1;
        in_valid = 1'b0;
        drive_beat(1'b0, 1'b0, 7'd64, 12'd21, 1'b1);
        drive_beat(1'b0, 1'b1, 7'd10, 12'd22, 1'b1);
        checks++;
        if ({desc_valid, desc_head, desc_tail, desc_len, desc_cells, desc_err} !==
            {1'b1, 12'd20, 12'd22, 14'd138, 6'd3, 1'b0}) begin
            errors++; $display("FAIL stall_desc: got h=%0d t=%0d len=%0d cells=%0d err=%b want 20/22/138/3/0",
                               desc_head, desc_tail, desc_len, desc_cells, desc_err);
        end
        checks++;
        if (wr_q.size() != 3 || link_q.size() != 2 || link_q[0] !== {12'd20, 12'd21} ||
            link_q[1] !== {12'd21, 12'd22}) begin
            errors++; $display("FAIL stall_links: got %0d writes %0d links, want 3/2 (20->21),(21->22)",
                               wr_q.size(), link_q.size());
        end
        consume_desc();
    endtask

    task automatic test_idle_drop();
        wr_q.delete();
        drive_beat(1'b0, 1'b0, 7'd33, 12'd30, 1'b0);
        @(negedge clk_dp);
        checks++;
        if (drop_cnt !== 16'd1 || wr_q.size() != 0 || desc_valid !== 1'b0) begin
            errors++; $display("FAIL idle_drop: got drop=%0d writes=%0d desc_valid=%b want 1/0/0",
                               drop_cnt, wr_q.size(), desc_valid);
        end
    endtask

    task automatic test_truncate();
        wr_q.delete(); link_q.delete();
        for (int i = 0; i < 40; i++)
            drive_beat(i == 0, i == 39, 7'd64, CELL_ID_W'(100 + i), i < MAX_CELLS);
        @(negedge clk_dp);
        checks++;
        if (wr_q.size() != 32 || link_q.size() != 31) begin
            errors++; $display("FAIL trunc_count: got %0d writes %0d links want 32/31", wr_q.size(), link_q.size());
        end else begin
            checks++;
            if (wr_q[31] !== '{12'd131, 1'b0, 1'b1, 7'd64} || wr_q[30].eof !== 1'b0) begin
                errors++; $display("FAIL trunc_last: got id=%0d eof=%b prev_eof=%b want 131/1/0",
                                   wr_q[31].id, wr_q[31].eof, wr_q[30].eof);
            end
        end
        checks++;
        if ({desc_valid, desc_head, desc_tail, desc_len, desc_cells, desc_err} !==
            {1'b1, 12'd100, 12'd131, 14'd2048, 6'd32, 1'b1}) begin
            errors++; $display("FAIL trunc_desc: got v=%b h=%0d t=%0d len=%0d cells=%0d err=%b want 1/100/131/2048/32/1",
                               desc_valid, desc_head, desc_tail, desc_len, desc_cells, desc_err);
        end
        checks++;
        if (err_cnt !== 16'd1) begin
            errors++; $display("FAIL trunc_err_cnt: got %0d want 1", err_cnt);
        end
        consume_desc();
    endtask

    task automatic test_desc_stall();
        drive_beat(1'b1, 1'b1, 7'd17, 12'd40, 1'b1);
        in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1; in_len = 7'd5;
        alloc_id = 12'd41; in_data = pattern(12'd41);
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || desc_valid !== 1'b1 || desc_head !== 12'd40 || desc_len !== 14'd17) begin
                errors++; $display("FAIL desc_hold cyc%0d: in_ready=%b v=%b h=%0d len=%0d want 0/1/40/17",
                                   i, in_ready, desc_valid, desc_head, desc_len);
            end
            @(negedge clk_dp);
        end
        desc_ready = 1'b1;
        @(negedge clk_dp);
        desc_ready = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        checks++;
        if ({desc_valid, desc_head, desc_len, wr_valid, wr_cell_id} !== {1'b1, 12'd41, 14'd5, 1'b1, 12'd41}) begin
            errors++; $display("FAIL desc_swap: got v=%b h=%0d len=%0d wr_v=%b wr_id=%0d want 1/41/5/1/41",
                               desc_valid, desc_head, desc_len, wr_valid, wr_cell_id);
        end
        consume_desc();
    endtask

    task automatic test_body_sof();
        wr_q.delete();
        drive_beat(1'b1, 1'b0, 7'd64, 12'd70, 1'b1);
        drive_beat(1'b1, 1'b1, 7'd3, 12'd71, 1'b1);
        @(negedge clk_dp);
        checks++;
        if ({desc_head, desc_tail, desc_len, desc_cells, desc_err, err_cnt} !==
            {12'd70, 12'd71, 14'd67, 6'd2, 1'b0, 16'd2}) begin
            errors++; $display("FAIL body_sof: got h=%0d t=%0d len=%0d cells=%0d err=%b err_cnt=%0d want 70/71/67/2/0/2",
                               desc_head, desc_tail, desc_len, desc_cells, desc_err, err_cnt);
        end
        checks++;
        if (wr_q.size() != 2 || wr_q[1].sof !== 1'b0) begin
            errors++; $display("FAIL body_sof_flag: got %0d writes, want 2 with second wr_sof=0", wr_q.size());
        end
        consume_desc();
    endtask

    task automatic test_reset_mid_packet();
        drive_beat(1'b1, 1'b0, 7'd64, 12'd50, 1'b1);
        drive_beat(1'b0, 1'b0, 7'd64, 12'd51, 1'b1);
        rst_dp = 1'b1;
        #1;
        checks++;
        if ({wr_valid, link_we, desc_valid, wr_cell_id, link_cell, drop_cnt, err_cnt} !== '0) begin
            errors++; $display("FAIL reset_mid: got wr_v=%b link=%b desc=%b wr_id=%0d drop=%0d err=%0d want all 0",
                               wr_valid, link_we, desc_valid, wr_cell_id, drop_cnt, err_cnt);
        end
        @(negedge clk_dp);
        rst_dp = 1'b0;
        @(negedge clk_dp);
        drive_beat(1'b1, 1'b1, 7'd12, 12'd60, 1'b1);
        checks++;
        if ({desc_valid, desc_head, desc_tail, desc_len, desc_cells, desc_err} !==
            {1'b1, 12'd60, 12'd60, 14'd12, 6'd1, 1'b0}) begin
            errors++; $display("FAIL reset_fresh: got v=%b h=%0d t=%0d len=%0d cells=%0d want 1/60/60/12/1",
                               desc_valid, desc_head, desc_tail, desc_len, desc_cells);
        end
        consume_desc();
    endtask

    initial begin
        rst_dp = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_len = '0;
        in_data = '0; alloc_valid = 1'b1; alloc_id = '0; desc_ready = 1'b0;
        @(negedge clk_dp);
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_alloc_stall();
        test_idle_drop();
        test_truncate();
        test_desc_stall();
        test_body_sof();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
